// File: rtl/m0_pkg.sv
// Flop primitives package: default word width, word type and reset value
// shared by the D-type register primitive and its bench.
package m0_pkg;

   localparam int DEFAULT_WIDTH = 2;

   typedef logic [DEFAULT_WIDTH-1:0] word_t;

   localparam word_t DEFAULT_RST_VAL = '0;

endpackage : m0_pkg

// File: rtl/m0_dff_ar_cell.sv
// Single-bit D flip-flop with asynchronous active-high reset and a
// parameterized reset bit. This is the leaf cell of the m0 register.
module dff_ar_cell #(
   parameter logic RST_BIT = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic r_q;

   // Capture D on every rising clock edge; reset overrides immediately.
   // NOTE: non-blocking assignment keeps the register update race-free
   // against every other process sampling r_q on the same edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_q <= RST_BIT;
      end else begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule : dff_ar_cell

// File: rtl/m0.sv
// m0: WIDTH-bit D-type storage register with asynchronous active-high
// reset. Built from WIDTH independent dff_ar_cell instances, so each bit of
// Q depends only on the same bit of D and on SRST.
module m0
   import m0_pkg::*;
#(
   parameter int               WIDTH   = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEFAULT_RST_VAL)
) (
   input  logic             CLK,
   input  logic             SRST,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q
);

   logic [WIDTH-1:0] w_q;

   // One flip-flop per bit; bit i of RST_VAL is that cell's reset bit.
   for (genvar g_bit = 0; g_bit < WIDTH; g_bit++) begin : g_cell
      dff_ar_cell #(
         .RST_BIT (RST_VAL[g_bit])
      ) u_cell (
         .i_clk (CLK),
         .i_rst (SRST),
         .i_d   (D[g_bit]),
         .o_q   (w_q[g_bit])
      );
   end

   assign Q = w_q;

`ifndef SYNTHESIS
   // Simulation-only behavioural checks.
   logic [WIDTH-1:0] r_d_prev;
   logic             r_armed;
   logic             r_rst_prev;

   // Remember the D captured at each edge and whether that edge was a real
   // capture (reset low), so the next edge can confirm Q reflects it.
   // Reading Q here sees its pre-edge value, since the cells update late.
   // NOTE: the checker state is reset too, so a reset pulse between edges
   // never leaves a stale "expect capture" flag behind.
   always_ff @(posedge CLK or posedge SRST) begin
      if (SRST) begin
         r_armed    <= 1'b0;
         r_rst_prev <= 1'b1;
         r_d_prev   <= '0;
      end else begin
         if (r_armed) begin
            assert (Q == r_d_prev)
               else $error("m0: Q=%b does not match previous-edge D=%b", Q, r_d_prev);
         end
         r_armed    <= 1'b1;
         r_rst_prev <= 1'b0;
         r_d_prev   <= D;
      end
   end

   // While reset has been held across a full clock edge, Q must sit at RST_VAL.
   always_ff @(posedge CLK) begin
      if (SRST && r_rst_prev) begin
         assert (Q == RST_VAL)
            else $error("m0: Q=%b not at reset value %b during reset", Q, RST_VAL);
      end
   end
`endif

endmodule : m0

// File: tb/tb_m0.sv
// Self-checking bench for m0: table-driven cycle vectors through a
// scoreboard queue, plus hand-written async reset and coincident-edge cases.
module tb_m0;
   import m0_pkg::*;

   localparam int    W    = DEFAULT_WIDTH;
   localparam word_t RSTV = DEFAULT_RST_VAL;

   logic  clk;
   logic  srst;
   word_t d;
   word_t q;

   int n_checks;
   int n_errors;

   word_t sb_q[$];

   typedef struct {
      logic  srst;
      word_t d;
      word_t exp_q;
   } vec_t;

   vec_t vecs[12];

   m0 #(
      .WIDTH   (W),
      .RST_VAL (RSTV)
   ) dut (
      .CLK  (clk),
      .SRST (srst),
      .D    (d),
      .Q    (q)
   );

   // 10 ns clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Absolute time bound so the run always terminates.
   initial begin
      #20000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input word_t act, input word_t exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: Q=%b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic sb_compare(input string name);
      word_t exp;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: scoreboard empty, Q=%b at %0t", name, q, $time);
      end else begin
         exp = sb_q.pop_front();
         check(name, q, exp);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;

      // srst, d, expected Q after the following rising edge
      vecs[0]  = '{1'b0, 2'b00, 2'b00};
      vecs[1]  = '{1'b1, 2'b00, 2'b00};
      vecs[2]  = '{1'b1, 2'b11, 2'b00};
      vecs[3]  = '{1'b0, 2'b01, 2'b01};
      vecs[4]  = '{1'b0, 2'b10, 2'b10};
      vecs[5]  = '{1'b0, 2'b11, 2'b11};
      vecs[6]  = '{1'b0, 2'b01, 2'b01};
      vecs[7]  = '{1'b0, 2'b10, 2'b10};
      vecs[8]  = '{1'b0, 2'b01, 2'b01};
      vecs[9]  = '{1'b1, 2'b10, 2'b00};
      vecs[10] = '{1'b0, 2'b10, 2'b10};
      vecs[11] = '{1'b0, 2'b00, 2'b00};

      // Reset state at power-up.
      srst = 1'b1;
      d    = 2'b11;
      #1;
      check("reset_state", q, RSTV);

      // Table-driven vectors: drive on falling edge, compare after rising edge.
      for (int i = 0; i < 12; i++) begin
         word_t q_before;
         @(negedge clk);
         q_before = q;
         srst = vecs[i].srst;
         d    = vecs[i].d;
         sb_q.push_back(vecs[i].exp_q);
         #1;
         if (vecs[i].srst) begin
            check($sformatf("vec%0d_async_rst", i), q, RSTV);
         end else begin
            check($sformatf("vec%0d_no_fall_change", i), q, q_before);
         end
         @(posedge clk);
         #1;
         sb_compare($sformatf("vec%0d_capture", i));
      end

      // Async assertion mid-cycle: Q clears before any clock edge.
      @(negedge clk);
      srst = 1'b0;
      d    = 2'b11;
      sb_q.push_back(2'b11);
      @(posedge clk);
      #1;
      sb_compare("load_11");
      #2;
      srst = 1'b1;
      #1;
      check("async_assert_midcycle", q, RSTV);
      // Deassertion alone leaves Q at reset value until the next rising edge.
      @(negedge clk);
      srst = 1'b0;
      d    = 2'b10;
      #1;
      check("deassert_no_effect", q, RSTV);
      sb_q.push_back(2'b10);
      @(posedge clk);
      #1;
      sb_compare("first_capture_after_deassert");

      // Reset coincident with a rising edge while D=11 and Q=01: reset wins.
      @(negedge clk);
      d = 2'b01;
      sb_q.push_back(2'b01);
      @(posedge clk);
      #1;
      sb_compare("load_01");
      @(negedge clk);
      d = 2'b11;
      @(posedge clk);
      srst = 1'b1;
      #1;
      check("coincident_rst_wins", q, RSTV);
      @(negedge clk);
      srst = 1'b0;
      d    = 2'b11;
      #1;
      check("coincident_deassert_hold", q, RSTV);
      sb_q.push_back(2'b11);
      @(posedge clk);
      #1;
      sb_compare("coincident_recapture");

      if (sb_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_m0
